mem_port_arbiter: RTL and testbench

- Shares the single-ported 64K x 16 main memory between the instruction-fetch stage and the load/store (ALU/data) stage of the pipelined processor.
- Grants at most one access per cycle and tags each access so its read data returns to the correct requester after the fixed memory latency.
- Enforces a data-first policy with a starvation bound for fetch.
- Drives stall and squash-aware response-valid signals back to the pipeline.

---
 rtl/mem_port_arbiter_pkg.sv | 13 +
 rtl/mem_port_arbiter_arb_pick.sv | 11 +
 rtl/mem_port_arbiter.sv | 119 +++++++++++
 tb/tb_mem_port_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;
  localparam int WORD_W = 16;
  localparam int ADDR_W = 16;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D  = 1'b1;

  typedef struct packed {
    logic valid;
    logic id;
  } rsp_ent_t;
endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational grant decision: data wins unless fetch has hit its starvation bound.
module arb_pick (
  input  logic i_if_req,
  input  logic i_d_req,
  input  logic i_starved,
  output logic o_if_gnt,
  output logic o_d_gnt
);
  assign o_if_gnt = i_if_req & (~i_d_req | i_starved);
  assign o_d_gnt  = i_d_req & ~(i_if_req & i_starved);
endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between fetch and data stages with tagged response return.
// Optional ARB_STATS_EN adds conflict / forced-grant counters.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_stall,
  output logic              if_rvalid,
  output logic [WORD_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [WORD_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [WORD_W-1:0] d_rdata,
`ifdef ARB_STATS_EN
  output logic [15:0]       stat_conflicts,
  output logic [15:0]       stat_forced,
`endif
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata
);
  localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_MAX);

  logic [3:0]        r_starve_cnt;
  logic              w_starved, w_if_pick, w_d_pick;
  rsp_ent_t          r_line [MEM_LAT];
  rsp_ent_t          w_push, w_tail;
  logic              w_tail_live;
  logic [WORD_W-1:0] r_if_hold, r_d_hold;

  assign w_starved = (r_starve_cnt == LP_STARVE_MAX);

  arb_pick u_pick (
    .i_if_req  (if_req),
    .i_d_req   (d_req),
    .i_starved (w_starved),
    .o_if_gnt  (w_if_pick),
    .o_d_gnt   (w_d_pick)
  );

  // Grants are gated by reset so nothing reaches memory while held in reset.
  assign if_gnt   = w_if_pick & reset;
  assign d_gnt    = w_d_pick & reset;
  assign if_stall = if_req & ~if_gnt;

  assign mem_en    = if_gnt | d_gnt;
  assign mem_we    = d_gnt & d_we;
  assign mem_addr  = d_gnt ? d_addr : (if_gnt ? if_addr : '0);
  assign mem_wdata = d_gnt ? d_wdata : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  r_starve_cnt <= '0;
    else if (if_req && !if_gnt)  r_starve_cnt <= w_starved ? r_starve_cnt : r_starve_cnt + 4'd1;
    else                         r_starve_cnt <= '0;
  end

  assign w_push.valid = mem_en & ~mem_we;
  assign w_push.id    = d_gnt ? REQ_D : REQ_IF;

  // Fetch entries are killed as they advance while if_flush is high; a new push survives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MEM_LAT; i++) r_line[i] <= '0;
    end else begin
      r_line[0] <= w_push;
      for (int i = 1; i < MEM_LAT; i++) begin
        r_line[i].id    <= r_line[i-1].id;
        r_line[i].valid <= r_line[i-1].valid & ~(if_flush & (r_line[i-1].id == REQ_IF));
      end
    end
  end

  assign w_tail      = r_line[MEM_LAT-1];
  assign w_tail_live = w_tail.valid & ~(if_flush & (w_tail.id == REQ_IF));
  assign if_rvalid   = w_tail_live & (w_tail.id == REQ_IF);
  assign d_rvalid    = w_tail_live & (w_tail.id == REQ_D);
  assign if_rdata    = if_rvalid ? mem_rdata : r_if_hold;
  assign d_rdata     = d_rvalid ? mem_rdata : r_d_hold;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_if_hold <= '0;
      r_d_hold  <= '0;
    end else begin
      if (if_rvalid) r_if_hold <= mem_rdata;
      if (d_rvalid)  r_d_hold  <= mem_rdata;
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] r_conflicts, r_forced;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_conflicts <= '0;
      r_forced    <= '0;
    end else begin
      if (if_req && d_req && r_conflicts != 16'hFFFF) r_conflicts <= r_conflicts + 16'd1;
      if (if_gnt && d_req && r_forced != 16'hFFFF)    r_forced    <= r_forced + 16'd1;
    end
  end

  assign stat_conflicts = r_conflicts;
  assign stat_forced    = r_forced;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: three arbiters (MEM_LAT 1..3) each with a latency-matched memory model.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        if_req [3], if_flush [3], if_gnt [3], if_stall [3], if_rvalid [3];
  logic [15:0] if_addr [3], if_rdata [3];
  logic        d_req [3], d_we [3], d_gnt [3], d_rvalid [3];
  logic [15:0] d_addr [3], d_wdata [3], d_rdata [3];
  logic        mem_en [3], mem_we [3];
  logic [15:0] mem_addr [3], mem_wdata [3], mem_rdata [3];
`ifdef ARB_STATS_EN
  logic [15:0] stat_conflicts [3], stat_forced [3];
`endif

  int n_tests = 0;
  int n_fail  = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = g + 1;
    logic [255:0] wr = '0;
    logic [15:0]  wmem [256];
    logic [15:0]  pipe [L];
    logic [7:0]   a8;
    logic [15:0]  rdv;

    // Unwritten cells read as 0x100 + address; idle slots carry 0xDEAD.
    assign a8  = mem_addr[g][7:0];
    assign rdv = wr[a8] ? wmem[a8] : (16'h0100 + {8'h00, a8});
    always @(posedge clk) begin
      if (mem_en[g] && mem_we[g]) begin
        wmem[a8] <= mem_wdata[g];
        wr[a8]   <= 1'b1;
      end
      pipe[0] <= (mem_en[g] && !mem_we[g]) ? rdv : 16'hDEAD;
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata[g] = pipe[L-1];

    mem_port_arbiter #(.MEM_LAT(L), .STARVE_MAX(3)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .if_req    (if_req[g]),
      .if_addr   (if_addr[g]),
      .if_flush  (if_flush[g]),
      .if_gnt    (if_gnt[g]),
      .if_stall  (if_stall[g]),
      .if_rvalid (if_rvalid[g]),
      .if_rdata  (if_rdata[g]),
      .d_req     (d_req[g]),
      .d_we      (d_we[g]),
      .d_addr    (d_addr[g]),
      .d_wdata   (d_wdata[g]),
      .d_gnt     (d_gnt[g]),
      .d_rvalid  (d_rvalid[g]),
      .d_rdata   (d_rdata[g]),
`ifdef ARB_STATS_EN
      .stat_conflicts (stat_conflicts[g]),
      .stat_forced    (stat_forced[g]),
`endif
      .mem_en    (mem_en[g]),
      .mem_we    (mem_we[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_all();
    for (int k = 0; k < 3; k++) begin
      if_req[k] = 1'b0; if_addr[k] = '0; if_flush[k] = 1'b0;
      d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0;
    end
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    bit pif, eif;
    idle_all();
    reset = 1'b0;

    // Reset: requests present but nothing may be granted or driven.
    if_req[0] = 1'b1; if_addr[0] = 16'h5678;
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 16'h1234; d_wdata[0] = 16'hAAAA;
    repeat (2) @(posedge clk);
    smp();
    chk("rst_if_gnt", if_gnt[0], 0);
    chk("rst_d_gnt", d_gnt[0], 0);
    chk("rst_mem_en", mem_en[0], 0);
    chk("rst_mem_we", mem_we[0], 0);
    chk("rst_mem_addr", mem_addr[0], 0);
    chk("rst_mem_wdata", mem_wdata[0], 0);
    chk("rst_if_rvalid", if_rvalid[0], 0);
    chk("rst_d_rvalid", d_rvalid[0], 0);
    chk("rst_if_rdata", if_rdata[0], 0);
    chk("rst_d_rdata", d_rdata[0], 0);
    idle_all();
    reset = 1'b1;
    nxt();

    // 1: fetch-only stream, MEM_LAT=1
    for (int c = 0; c < 5; c++) begin
      if (c < 4) begin if_req[0] = 1'b1; if_addr[0] = 16'(c); end
      else if_req[0] = 1'b0;
      smp();
      if (c < 4) chk("t1_if_gnt", if_gnt[0], 1);
      if (c > 0) begin
        chk("t1_if_rvalid", if_rvalid[0], 1);
        chk("t1_if_rdata", if_rdata[0], 32'h100 + c - 1);
      end
      chk("t1_d_rvalid", d_rvalid[0], 0);
      nxt();
    end
    smp();
    chk("t1_if_rvalid_end", if_rvalid[0], 0);
    chk("t1_if_rdata_hold", if_rdata[0], 16'h103);
    nxt();

    // 2: conflict with starvation bound 3 -> D,D,D,IF,D,D,D,IF
    pif = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if_req[0] = 1'b1; if_addr[0] = 16'h0050;
      d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 16'(16'h0030 + c);
      smp();
      eif = (c == 3 || c == 7);
      chk("t2_if_gnt", if_gnt[0], eif);
      chk("t2_d_gnt", d_gnt[0], !eif);
      chk("t2_if_stall", if_stall[0], !eif);
      if (c > 0) begin
        chk("t2_if_rvalid", if_rvalid[0], pif);
        chk("t2_d_rvalid", d_rvalid[0], !pif);
      end
      if (c == 1) chk("t2_d_rdata", d_rdata[0], 16'h130);
      pif = eif;
      nxt();
    end
    idle_all();
    smp();
    chk("t2_last_if_rvalid", if_rvalid[0], 1);
    chk("t2_last_if_rdata", if_rdata[0], 16'h150);
`ifdef ARB_STATS_EN
    chk("t2_stat_conflicts", stat_conflicts[0], 8);
    chk("t2_stat_forced", stat_forced[0], 2);
`endif
    nxt();
    nxt();

    // 3: store then load of the same address
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 16'h0040; d_wdata[0] = 16'hBEEF;
    smp();
    chk("t3_st_gnt", d_gnt[0], 1);
    chk("t3_st_mem_we", mem_we[0], 1);
    chk("t3_st_mem_addr", mem_addr[0], 16'h0040);
    chk("t3_st_mem_wdata", mem_wdata[0], 16'hBEEF);
    nxt();
    d_we[0] = 1'b0; d_wdata[0] = '0;
    smp();
    chk("t3_ld_gnt", d_gnt[0], 1);
    chk("t3_st_no_rvalid", d_rvalid[0], 0);
    nxt();
    idle_all();
    smp();
    chk("t3_ld_rvalid", d_rvalid[0], 1);
    chk("t3_ld_rdata", d_rdata[0], 16'hBEEF);
    nxt();
    smp();
    chk("t3_rvalid_1cyc", d_rvalid[0], 0);
    chk("t3_rdata_hold", d_rdata[0], 16'hBEEF);
    nxt();

    // 4: flush, MEM_LAT=3. Fetches at s=0..3 (t=1), flush at s=3; data load survives later flushes.
    for (int s = 0; s < 11; s++) begin
      idle_all();
      if (s < 4) begin if_req[2] = 1'b1; if_addr[2] = 16'(4 + s); end
      if (s == 3 || s == 8 || s == 9) if_flush[2] = 1'b1;
      if (s == 7) begin d_req[2] = 1'b1; d_addr[2] = 16'h0060; end
      smp();
      if (s < 4) chk("t4_if_gnt", if_gnt[2], 1);
      if (s >= 3) chk("t4_if_rvalid", if_rvalid[2], s == 6);
      if (s == 6) chk("t4_if_rdata", if_rdata[2], 16'h107);
      if (s >= 7) chk("t4_d_rvalid", d_rvalid[2], s == 10);
      if (s == 10) chk("t4_d_rdata", d_rdata[2], 16'h160);
      nxt();
    end
    idle_all();

    // 5: alternating IF/D reads, MEM_LAT=2
    for (int c = 0; c < 8; c++) begin
      idle_all();
      if (c < 6) begin
        if (c % 2 == 0) begin if_req[1] = 1'b1; if_addr[1] = 16'(16'h20 + c); end
        else begin d_req[1] = 1'b1; d_addr[1] = 16'(16'h20 + c); end
      end
      smp();
      if (c < 6) begin
        chk("t5_if_gnt", if_gnt[1], c % 2 == 0);
        chk("t5_d_gnt", d_gnt[1], c % 2 == 1);
      end
      if (c >= 2) begin
        chk("t5_if_rvalid", if_rvalid[1], (c - 2) % 2 == 0);
        chk("t5_d_rvalid", d_rvalid[1], (c - 2) % 2 == 1);
        if ((c - 2) % 2 == 0) begin
          chk("t5_if_rdata", if_rdata[1], 32'h120 + c - 2);
          if (c > 2) chk("t5_d_hold", d_rdata[1], 32'h120 + c - 3);
        end else begin
          chk("t5_d_rdata", d_rdata[1], 32'h120 + c - 2);
          chk("t5_if_hold", if_rdata[1], 32'h120 + c - 3);
        end
      end
      nxt();
    end
    idle_all();

    // 6: reset with reads outstanding (MEM_LAT=3), starve count built to 2
    for (int c = 0; c < 3; c++) begin
      if_req[2] = 1'b1; if_addr[2] = 16'h0070;
      d_req[2] = 1'b1; d_addr[2] = 16'h0071;
      smp();
      chk("t6_pre_d_gnt", d_gnt[2], 1);
      if (c < 2) nxt();
    end
    reset = 1'b0;
    idle_all();
    for (int j = 0; j < 2; j++) begin
      smp();
      chk("t6_rst_if_rvalid", if_rvalid[2], 0);
      chk("t6_rst_d_rvalid", d_rvalid[2], 0);
    end
    reset = 1'b1;
    nxt();
    for (int r = 0; r < 5; r++) begin
      idle_all();
      if (r < 4) begin
        if_req[2] = 1'b1; if_addr[2] = 16'h0070;
        d_req[2] = 1'b1; d_addr[2] = 16'h0072;
      end
      smp();
      if (r < 4) begin
        chk("t6_if_gnt", if_gnt[2], r == 3);
        chk("t6_d_gnt", d_gnt[2], r != 3);
      end
      if (r < 3) begin
        chk("t6_if_rvalid", if_rvalid[2], 0);
        chk("t6_d_rvalid", d_rvalid[2], 0);
      end
      if (r == 0) chk("t6_d_rdata_clr", d_rdata[2], 0);
      if (r == 3) begin
        chk("t6_new_d_rvalid", d_rvalid[2], 1);
        chk("t6_new_d_rdata", d_rdata[2], 16'h172);
      end
      nxt();
    end
    idle_all();
    repeat (4) nxt();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
